// File: rtl/ahb_mtx_pkg.sv
// rtl/ahb_mtx_pkg.sv - shared encodings, FSM state and control struct for the AHB matrix input stage
package ahb_mtx_pkg;

  localparam logic [1:0] TRN_IDLE = 2'b00;
  localparam logic [1:0] TRN_BUSY = 2'b01;
  localparam logic [1:0] TRN_NSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ  = 2'b11;

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Address-phase control; the address itself is kept separate because its width is a module parameter.
  typedef struct packed {
    logic       sel;
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic [3:0] master;
    logic       mastlock;
  } ctrl_t;

endpackage

// File: rtl/ahb_mtx_hold_reg.sv
// rtl/ahb_mtx_hold_reg.sv - address/control holding register; HAUSER flops only with AHB_MTX_USER_SIGNALS_EN
module ahb_mtx_hold_reg
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef AHB_MTX_USER_SIGNALS_EN
  ,
  parameter int USER_W = 32
`endif
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              load,
  input  ctrl_t             ctrl_d,
  input  logic [ADDR_W-1:0] addr_d,
`ifdef AHB_MTX_USER_SIGNALS_EN
  input  logic [USER_W-1:0] auser_d,
  output logic [USER_W-1:0] auser_q,
`endif
  output ctrl_t             ctrl_q,
  output logic [ADDR_W-1:0] addr_q
);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_q <= '0;
      addr_q <= '0;
    end else if (load) begin
      ctrl_q <= ctrl_d;
      addr_q <= addr_d;
    end
  end

`ifdef AHB_MTX_USER_SIGNALS_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      auser_q <= '0;
    end else if (load) begin
      auser_q <= auser_d;
    end
  end
`endif

endmodule

// File: rtl/ahb_mtx_input_stage.sv
// rtl/ahb_mtx_input_stage.sv - AHB matrix master-side input stage; AHB_MTX_USER_SIGNALS_EN forwards HAUSER
module ahb_mtx_input_stage
  import ahb_mtx_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int USER_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic [3:0]        HMASTERS,
  input  logic              HMASTLOCKS,
  input  logic [USER_W-1:0] HAUSERS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              sel_ip,
  output logic [ADDR_W-1:0] addr_ip,
  output logic [USER_W-1:0] auser_ip,
  output logic [1:0]        trans_ip,
  output logic              write_ip,
  output logic [2:0]        size_ip,
  output logic [2:0]        burst_ip,
  output logic [3:0]        prot_ip,
  output logic [3:0]        master_ip,
  output logic              mastlock_ip,
  output logic              held_tran_ip,
  input  logic              active_ip,
  input  logic              hreadymux_ip,
  input  logic [1:0]        resp_ip
);

  state_t            state, state_nxt;
  ctrl_t             ctrl_in, held_ctrl, ctrl_out;
  logic [ADDR_W-1:0] held_addr;
  logic              trans_req, acc, hold_load;

  assign ctrl_in = '{sel: HSELS, trans: HTRANSS, write: HWRITES, size: HSIZES, burst: HBURSTS,
                     prot: HPROTS, master: HMASTERS, mastlock: HMASTLOCKS};

  assign trans_req = HSELS & HTRANSS[1] & HREADYS;
  assign acc       = held_tran_ip & active_ip & hreadymux_ip;
  assign hold_load = (state != ST_HELD) && (state_nxt == ST_HELD);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (trans_req) state_nxt = acc ? ST_DATA : ST_HELD;
      ST_HELD: if (acc) state_nxt = ST_DATA;
      ST_DATA: begin
        if (hreadymux_ip) begin
          if (trans_req) state_nxt = acc ? ST_DATA : ST_HELD;
          else           state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The stalled master cannot present a new address while held, so the register stays stable.
  always_comb begin
    ctrl_out     = ctrl_in;
    addr_ip      = HADDRS;
    held_tran_ip = trans_req & ~HRESET;
    HREADYOUTS   = 1'b1;
    HRESPS       = RSP_OKAY;
    case (state)
      ST_HELD: begin
        ctrl_out     = held_ctrl;
        addr_ip      = held_addr;
        held_tran_ip = 1'b1;
        HREADYOUTS   = 1'b0;
      end
      ST_DATA: begin
        HREADYOUTS = hreadymux_ip;
        HRESPS     = resp_ip;
      end
      default: ;
    endcase
  end

  assign sel_ip      = ctrl_out.sel;
  assign trans_ip    = ctrl_out.trans;
  assign write_ip    = ctrl_out.write;
  assign size_ip     = ctrl_out.size;
  assign burst_ip    = ctrl_out.burst;
  assign prot_ip     = ctrl_out.prot;
  assign master_ip   = ctrl_out.master;
  assign mastlock_ip = ctrl_out.mastlock;

`ifdef AHB_MTX_USER_SIGNALS_EN
  logic [USER_W-1:0] held_auser;

  ahb_mtx_hold_reg #(.ADDR_W(ADDR_W), .USER_W(USER_W)) u_hold (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .load    (hold_load),
    .ctrl_d  (ctrl_in),
    .addr_d  (HADDRS),
    .auser_d (HAUSERS),
    .auser_q (held_auser),
    .ctrl_q  (held_ctrl),
    .addr_q  (held_addr)
  );

  assign auser_ip = (state == ST_HELD) ? held_auser : HAUSERS;
`else
  logic unused_auser;

  ahb_mtx_hold_reg #(.ADDR_W(ADDR_W)) u_hold (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .load   (hold_load),
    .ctrl_d (ctrl_in),
    .addr_d (HADDRS),
    .ctrl_q (held_ctrl),
    .addr_q (held_addr)
  );

  assign auser_ip     = '0;
  assign unused_auser = ^HAUSERS;
`endif

endmodule

// File: doc/ahb_mtx_input_stage.md
Name: ahb_mtx_input_stage

Overview:
- Master-side input stage of the L1 AHB bus matrix; one instance per master port.
- Sits directly upstream of the per-slave output stages (via the address decoder); it produces the sel/addr/trans/.../held_tran signals those stages arbitrate on.
- Captures an address phase that the targeted output stage cannot accept immediately, stalls the master with HREADYOUTS low, and replays the held transfer until granted.
- Returns data-phase ready and response signals to the master.

Parameters:
- ADDR_W, 32, address width
- USER_W, 32, HAUSER/HWUSER width

Ports:
- HCLK  in  1  AHB clock
- HRESET  in  1  asynchronous, active-high reset
- HSELS  in  1  master select
- HADDRS  in  ADDR_W  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  direction
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HMASTERS  in  4  master ID
- HMASTLOCKS  in  1  lock
- HAUSERS  in  USER_W  address user
- HREADYS  in  1  master-side HREADY
- HREADYOUTS  out  1  ready to master
- HRESPS  out  2  response to master
- sel_ip  out  1  forwarded HSEL
- addr_ip  out  ADDR_W  forwarded address
- auser_ip  out  USER_W  forwarded HAUSER
- trans_ip  out  2  forwarded HTRANS
- write_ip  out  1  forwarded HWRITE
- size_ip  out  3  forwarded HSIZE
- burst_ip  out  3  forwarded HBURST
- prot_ip  out  4  forwarded HPROT
- master_ip  out  4  forwarded HMASTER
- mastlock_ip  out  1  forwarded HMASTLOCK
- held_tran_ip  out  1  pending transfer request
- active_ip  in  1  targeted output stage has granted this port
- hreadymux_ip  in  1  HREADYMUX of the output stage owning the current phase
- resp_ip  in  2  slave response for the current data phase

Behaviour:
- trans_req = HSELS & HTRANSS[1] & HREADYS (NONSEQ/SEQ sampled).
- acc = held_tran_ip & active_ip & hreadymux_ip.
- FSM states: ST_IDLE, ST_HELD, ST_DATA.
  - ST_IDLE:
    - trans_req & acc -> ST_DATA.
    - trans_req & ~acc -> ST_HELD; address/control are registered.
  - ST_HELD: acc -> ST_DATA; otherwise stay.
  - ST_DATA:
    - hreadymux_ip & trans_req & acc -> ST_DATA.
    - hreadymux_ip & trans_req & ~acc -> ST_HELD.
    - hreadymux_ip & ~trans_req -> ST_IDLE.
    - ~hreadymux_ip -> stay.
- Output mux:
  - In ST_HELD, all *_ip outputs come from the holding register, and held_tran_ip=1.
  - Otherwise the *_ip outputs are combinational pass-through of the master inputs, and held_tran_ip=trans_req.
- HREADYOUTS:
  - ST_HELD: 0.
  - ST_DATA: hreadymux_ip.
  - ST_IDLE: 1.
- HRESPS:
  - ST_DATA: resp_ip.
  - Otherwise OKAY (2'b00).
  - A two-cycle ERROR is passed through unchanged.
- IDLE/BUSY transfers are never held. They receive a zero-wait OKAY and never assert held_tran_ip.
- A held SEQ is replayed unchanged as SEQ. The master is stalled, so no new address can arrive while in ST_HELD.
- HMASTLOCK is held in the register with the transfer. A locked sequence is not broken by a hold.
- Holding register loads only on the ST_IDLE/ST_DATA -> ST_HELD edge. It is stable for the whole hold.
- Reset values:
  - State ST_IDLE; holding register all zeros.
  - HREADYOUTS=1, HRESPS=OKAY, held_tran_ip=0.
  - sel_ip and trans_ip follow the inputs (pass-through).
- Reset asserted mid-hold or mid-data-phase: return to ST_IDLE immediately and discard the held transfer.
- Latency:
  - Granted transfer: zero added cycles.
  - Held transfer: one wait state per cycle without grant.

Optional Feature:
- Macro: AHB_MTX_USER_SIGNALS_EN.
- Defined: HAUSERS is registered in the holding register and forwarded on auser_ip.
- Undefined: auser_ip is tied to zero, and no USER_W flops are instantiated.

Decomposition:
- Package ahb_mtx_pkg holds:
  - HTRANS encodings (TRN_IDLE/BUSY/NSEQ/SEQ).
  - HRESP encodings (RSP_OKAY/ERROR).
  - FSM state enum.
  - Address/control struct type.
- One natural sub-module: ahb_mtx_hold_reg, the address/control holding register with load enable and async-high reset.

Test Plan:
- Grant available: NONSEQ write to 0x2000_0000 with active_ip=1, hreadymux_ip=1 -> held_tran_ip=1 in the same cycle, HREADYOUTS=1, no hold, data phase enters ST_DATA.
- Contention: NONSEQ read to 0x4000_0010 with active_ip=0 for 3 cycles -> ST_HELD, HREADYOUTS=0 for 3 cycles, addr_ip=0x4000_0010 stable; active_ip rises -> ST_DATA next cycle.
- Slave wait plus ERROR: in ST_DATA, hreadymux_ip=0 for 2 cycles -> HREADYOUTS=0; then resp_ip=ERROR over 2 cycles -> HRESPS=ERROR with HREADYOUTS 0 then 1.
- IDLE/BUSY: HTRANSS=BUSY with HSELS=1 -> held_tran_ip=0, HREADYOUTS=1, HRESPS=OKAY.
- Reset mid-hold: HRESET asserted in ST_HELD -> held_tran_ip=0, HREADYOUTS=1 asynchronously, holding register=0.
- Locked INCR4 with a hold on beat 2 -> mastlock_ip stays 1 through the hold; beats forwarded as NSEQ, SEQ, SEQ, SEQ.
